// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// FSM state encoding, default register addresses and status bit positions.
// Optional build macro used by the transmitter: MMIO_UART_PARITY_EN.
package mmio_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    localparam logic [31:0] DEF_DATA_ADDR = 32'hFFFF_FF00;
    localparam logic [31:0] DEF_STAT_ADDR = 32'hFFFF_FF04;

    // Bit positions in the status register
    localparam int unsigned ST_BUSY  = 0;
    localparam int unsigned ST_EMPTY = 1;
    localparam int unsigned ST_FULL  = 2;
    localparam int unsigned ST_OVF   = 3;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned BYTE_W = 8;

    // Even parity bit: set when the byte holds an odd number of ones
    function automatic logic even_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus view of the UART: store strobe, address, store data, and the
// combinational read data / select returned to the CPU read mux.
//   master: CPU side (drives we/a/wd, receives rd/sel)
//   slave : peripheral side
interface mmio_uart_tx_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        sel;

    modport master (output we, output a, output wd, input rd, input sel);
    modport slave  (input we, input a, input wd, output rd, output sel);
endinterface

// File: rtl/mmio_uart_tx_byte_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
// Ports: clk, reset (async active-low), push/din (write), pop/dout (read),
//        empty/full flags derived from the pointers.
// Pushes while full and pops while empty are ignored.
module byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en_c, rd_en_c;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_en_c  = push && !full;
        rd_en_c  = pop && !empty;
        wr_ptr_d = wr_ptr_q + PW'(wr_en_c);
        rd_ptr_d = rd_ptr_q + PW'(rd_en_c);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter on the CPU data bus.
// Stores to DATA_ADDR queue a byte; stores to STAT_ADDR with wd[3]=1 clear the
// sticky overflow flag. STAT_ADDR reads {ovf, full, empty, busy} in bits 3:0.
// Bytes are sent 8N1, LSB first, CLK_DIV clocks per bit; back-to-back frames
// run without an idle gap.
// Ports: clk, reset (async active-low), bus (slave: we/a/wd in, rd/sel out,
//        rd/sel combinational), txd (serial out, idle high), busy.
// Build macro MMIO_UART_PARITY_EN inserts an even-parity bit before stop.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] DATA_ADDR  = DEF_DATA_ADDR,
    parameter logic [31:0] STAT_ADDR  = DEF_STAT_ADDR
) (
    input  logic           clk,
    input  logic           reset,
    mmio_uart_tx_if.slave  bus,
    output logic           txd,
    output logic           busy
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;

    logic              hit_data_c, hit_stat_c;
    logic              push_c, pop_c, bit_end_c;
    logic [BYTE_W-1:0] fifo_dout;
    logic              fifo_empty, fifo_full;
    logic [BUS_W-1:0]  stat_c;
    logic              unused_wd_c;

    assign hit_data_c  = (bus.a == DATA_ADDR);
    assign hit_stat_c  = (bus.a == STAT_ADDR);
    assign push_c      = bus.we && hit_data_c;
    assign unused_wd_c = ^bus.wd[BUS_W-1:BYTE_W];

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .pop   (pop_c),
        .din   (bus.wd[BYTE_W-1:0]),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Transmit FSM: txd is registered, so each level is set on the edge that enters the bit
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop_c     = 1'b0;
        bit_end_c = (cnt_q == '0);

        if (state_q != S_IDLE) begin
            cnt_d = bit_end_c ? CNT_W'(CLK_DIV - 1) : cnt_q - CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_dout;
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    bit_idx_d = 3'd0;
                    txd_d     = shift_q[0];
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        txd_d   = even_parity(shift_q);
                        state_d = S_PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shift_q[bit_idx_d];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end_c) begin
                    txd_d   = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end_c) begin
                    // Chain straight into the next start bit when data is waiting
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shift_d = fifo_dout;
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        cnt_d   = '0;
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Sticky overflow: a store to a full FIFO is dropped even if a pop frees a slot that edge
    always_comb begin
        ovf_d = ovf_q;
        if (bus.we && hit_stat_c && bus.wd[ST_OVF]) begin
            ovf_d = 1'b0;
        end
        if (push_c && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    // Combinational register read for the CPU readdata mux
    always_comb begin
        stat_c           = '0;
        stat_c[ST_BUSY]  = busy_q;
        stat_c[ST_EMPTY] = fifo_empty;
        stat_c[ST_FULL]  = fifo_full;
        stat_c[ST_OVF]   = ovf_q;
        bus.sel          = hit_data_c || hit_stat_c;
        bus.rd           = hit_stat_c ? stat_c : '0;
    end

    assign txd  = txd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx (CLK_DIV=4, FIFO_DEPTH=8) against a frame-schedule model.
module tb_mmio_uart_tx;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DEPTH   = 8;
    localparam logic [31:0] DATA_A  = 32'hFFFF_FF00;
    localparam logic [31:0] STAT_A  = 32'hFFFF_FF04;
`ifdef MMIO_UART_PARITY_EN
    localparam int unsigned NBITS = 11;
    localparam logic [10:0] PAT55 = 11'h4AA;
`else
    localparam int unsigned NBITS = 10;
    localparam logic [10:0] PAT55 = 11'h6AA;
`endif
    localparam int unsigned FL = NBITS * CLK_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic txd, busy;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH),
        .DATA_ADDR  (DATA_A),
        .STAT_ADDR  (STAT_A)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus),
        .txd   (txd),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Model: every accepted byte becomes a frame with a start edge; the line is
    // derived from the frame list, FIFO occupancy from push/start edges.
    int unsigned f_push[$];
    int unsigned f_start[$];
    logic [7:0]  f_byte[$];
    int unsigned ov_edge[$];
    logic        ov_val[$];

    task automatic m_reset();
        f_push.delete();
        f_start.delete();
        f_byte.delete();
        ov_edge.delete();
        ov_val.delete();
    endtask

    task automatic m_push(input int unsigned p, input logic [7:0] b);
        int unsigned n = 0;
        int unsigned s;
        foreach (f_push[i]) if (f_push[i] < p && f_start[i] >= p) n++;
        if (n >= DEPTH) begin
            ov_edge.push_back(p);
            ov_val.push_back(1'b1);
        end else begin
            s = p + 1;
            if (f_start.size() > 0 && f_start[$] + FL > s) s = f_start[$] + FL;
            f_push.push_back(p);
            f_start.push_back(s);
            f_byte.push_back(b);
        end
    endtask

    function automatic logic m_txd(input int unsigned t);
        logic [7:0]  b;
        int unsigned k;
        foreach (f_start[i]) begin
            if (t >= f_start[i] && t < f_start[i] + FL) begin
                b = f_byte[i];
                k = (t - f_start[i]) / CLK_DIV;
                if (k == 0) return 1'b0;
                if (k <= 8) return b[k-1];
`ifdef MMIO_UART_PARITY_EN
                if (k == 9) return ^b;
`endif
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic m_busy(input int unsigned t);
        foreach (f_start[i]) if (t >= f_start[i] && t < f_start[i] + FL) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_stat(input int unsigned t);
        int unsigned n = 0;
        logic ov = 1'b0;
        foreach (f_push[i]) if (f_push[i] <= t && f_start[i] > t) n++;
        foreach (ov_edge[i]) if (ov_edge[i] <= t) ov = ov_val[i];
        return {28'b0, ov, (n == DEPTH), (n == 0), m_busy(t)};
    endfunction

    // Applies bus inputs for the next edge and records their effect in the model
    task automatic drive(input logic w, input logic [31:0] addr, input logic [31:0] data);
        bus.we = w;
        bus.a  = addr;
        bus.wd = data;
        if (w && addr == DATA_A) m_push(cyc + 1, data[7:0]);
        if (w && addr == STAT_A && data[3]) begin
            ov_edge.push_back(cyc + 1);
            ov_val.push_back(1'b0);
        end
    endtask

    task automatic test_reset();
        drive(1'b0, STAT_A, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_line: txd=%b busy=%b expected txd=1 busy=0", txd, busy);
        end
        n_checks++;
        if (bus.rd !== 32'h2 || bus.sel !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_stat: rd=%h sel=%b expected rd=00000002 sel=1", bus.rd, bus.sel);
        end
        m_reset();
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || bus.rd !== 32'h2) begin
            n_errors++;
            $display("FAIL post_reset: txd=%b busy=%b rd=%h expected 1 0 00000002", txd, busy, bus.rd);
        end
    endtask

    // One frame from idle: model-checked line plus explicit mid-bit pattern, latency, busy length
    task automatic test_frame(input logic [7:0] b, input logic [10:0] pat);
        int unsigned p, s, k;
        int unsigned busy_cnt = 0;
        int unsigned first_low = 0;
        @(negedge clk);
        drive(1'b1, DATA_A, {24'h0, b});
        p = cyc + 1;
        s = p + 1;
        for (int i = 0; i < int'(FL) + 8; i++) begin
            @(negedge clk);
            drive(1'b0, STAT_A, 32'h0);
            #1;
            n_checks++;
            if (txd !== m_txd(cyc) || busy !== m_busy(cyc)) begin
                n_errors++;
                $display("FAIL frame_line cyc=%0d: txd=%b busy=%b expected %b %b", cyc, txd, busy, m_txd(cyc), m_busy(cyc));
            end
            if (busy === 1'b1) busy_cnt++;
            if (txd === 1'b0 && first_low == 0) first_low = cyc;
            if (cyc >= s && cyc < s + FL && (cyc - s) % CLK_DIV == CLK_DIV / 2) begin
                k = (cyc - s) / CLK_DIV;
                n_checks++;
                if (txd !== pat[k]) begin
                    n_errors++;
                    $display("FAIL frame_bit%0d byte=%h: txd=%b expected %b", k, b, txd, pat[k]);
                end
            end
        end
        n_checks++;
        if (first_low != s) begin
            n_errors++;
            $display("FAIL start_latency: first low at %0d expected %0d", first_low, s);
        end
        n_checks++;
        if (busy_cnt != FL) begin
            n_errors++;
            $display("FAIL busy_len: %0d cycles expected %0d", busy_cnt, FL);
        end
        n_checks++;
        if (bus.rd !== 32'h2) begin
            n_errors++;
            $display("FAIL frame_stat_after: rd=%h expected 00000002", bus.rd);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, DATA_A, 32'(i));
        end
        for (int i = 0; i < 9 * int'(FL) + 20; i++) begin
            @(negedge clk);
            drive(1'b0, STAT_A, 32'h0);
            #1;
            n_checks++;
            if (txd !== m_txd(cyc) || busy !== m_busy(cyc) || bus.rd !== m_stat(cyc)) begin
                n_errors++;
                $display("FAIL ovf_run cyc=%0d: txd=%b busy=%b rd=%h expected %b %b %h", cyc, txd, busy, bus.rd, m_txd(cyc), m_busy(cyc), m_stat(cyc));
            end
            if (i == 0) begin
                n_checks++;
                if (bus.rd[3] !== 1'b1 || bus.rd[2] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL ovf_flag: rd=%h expected ovf=1 full=1", bus.rd);
                end
            end
        end
        n_checks++;
        if (bus.rd !== 32'hA) begin
            n_errors++;
            $display("FAIL ovf_drained: rd=%h expected 0000000a", bus.rd);
        end
        @(negedge clk);
        drive(1'b1, STAT_A, 32'h8);
        @(negedge clk);
        drive(1'b0, STAT_A, 32'h0);
        #1;
        n_checks++;
        if (bus.rd !== 32'h2) begin
            n_errors++;
            $display("FAIL ovf_clear: rd=%h expected 00000002", bus.rd);
        end
    endtask

    task automatic test_reset_midframe();
        int unsigned target;
        @(negedge clk);
        drive(1'b1, DATA_A, 32'hA5);
        target = cyc + 2 + 4 * CLK_DIV + 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            drive(1'b0, DATA_A, 32'h0);
            #1;
            n_checks++;
            if (txd !== m_txd(cyc)) begin
                n_errors++;
                $display("FAIL mid_line cyc=%0d: txd=%b expected %b", cyc, txd, m_txd(cyc));
            end
            if (cyc == target) break;
        end
        n_checks++;
        if (cyc != target || txd !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_bit3: cyc=%0d txd=%b expected cyc=%0d txd=0", cyc, txd, target);
        end
        rst_n = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: txd=%b busy=%b expected 1 0", txd, busy);
        end
        bus.a = STAT_A;
        #1;
        n_checks++;
        if (bus.rd !== 32'h2) begin
            n_errors++;
            $display("FAIL reset_fifo: rd=%h expected 00000002", bus.rd);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            drive(1'b0, STAT_A, 32'h0);
            #1;
            n_checks++;
            if (txd !== 1'b1 || busy !== 1'b0 || bus.rd !== 32'h2) begin
                n_errors++;
                $display("FAIL after_reset cyc=%0d: txd=%b busy=%b rd=%h expected 1 0 00000002", cyc, txd, busy, bus.rd);
            end
        end
    endtask

    task automatic test_no_sel();
        @(negedge clk);
        drive(1'b1, 32'h0000_0040, 32'h41);
        #1;
        n_checks++;
        if (bus.sel !== 1'b0 || bus.rd !== 32'h0) begin
            n_errors++;
            $display("FAIL nosel: sel=%b rd=%h expected 0 00000000", bus.sel, bus.rd);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            drive(1'b0, STAT_A, 32'h0);
            #1;
            n_checks++;
            if (txd !== 1'b1 || bus.rd !== 32'h2) begin
                n_errors++;
                $display("FAIL nosel_idle cyc=%0d: txd=%b rd=%h expected 1 00000002", cyc, txd, bus.rd);
            end
        end
    endtask

    task automatic test_random();
        int unsigned r;
        logic [31:0] exp_rd;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_checks++;
            if (txd !== m_txd(cyc) || busy !== m_busy(cyc)) begin
                n_errors++;
                $display("FAIL rand_line cyc=%0d: txd=%b busy=%b expected %b %b", cyc, txd, busy, m_txd(cyc), m_busy(cyc));
            end
            r = $urandom_range(0, 15);
            case (r)
                0:       drive(1'b1, DATA_A, $urandom);
                1:       drive(1'b1, STAT_A, $urandom);
                2:       drive(1'b1, 32'h0000_1000 + 32'($urandom_range(0, 255) * 4), $urandom);
                3:       drive(1'b0, DATA_A, $urandom);
                4:       drive(1'b0, 32'h0000_2000, $urandom);
                default: drive(1'b0, STAT_A, $urandom);
            endcase
            #1;
            exp_rd = (bus.a == STAT_A) ? m_stat(cyc) : 32'h0;
            n_checks++;
            if (bus.rd !== exp_rd || bus.sel !== (bus.a == STAT_A || bus.a == DATA_A)) begin
                n_errors++;
                $display("FAIL rand_read cyc=%0d a=%h: rd=%h sel=%b expected rd=%h", cyc, bus.a, bus.rd, bus.sel, exp_rd);
            end
        end
    endtask

    initial begin
        bus.we = 1'b0;
        bus.a  = 32'h0;
        bus.wd = 32'h0;
        test_reset();
        test_frame(8'h55, PAT55);
`ifdef MMIO_UART_PARITY_EN
        test_frame(8'h07, 11'h60E);
`endif
        test_overflow();
        test_reset_midframe();
        test_no_sel();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter hanging off the MIPS data bus, downstream of the CPU store path, in parallel with dmem.
- Consumes the CPU's store strobe, address and write data.
- Queues bytes written to a data register and serializes them onto a TX pin (8N1, LSB first).
- Exposes a status register for CPU polling; the top level muxes `rd` into readdata when `sel` is high.

Parameters:
CLK_DIV, 434, clock cycles per UART bit (≥2)
FIFO_DEPTH, 8, byte FIFO entries (power of 2, ≥2)
DATA_ADDR, 32'hFFFF_FF00, write-only TX data register address
STAT_ADDR, 32'hFFFF_FF04, status/control register address

Ports:
clk  in  1  system clock (the divided CPU clock)
reset  in  1  asynchronous, active-low reset
we  in  1  store strobe from CPU (memwrite)
a  in  32  bus address (aluout)
wd  in  32  store data (writedata)
rd  out  32  register read data (combinational)
sel  out  1  high when a == DATA_ADDR or a == STAT_ADDR
txd  out  1  serial output, idle high
busy  out  1  high while a frame is on the line

Behaviour:
- Reset (reset=0, asynchronous): txd=1, busy=0, FSM=IDLE, FIFO empty, ovf=0, baud counter=0. Reset mid-frame aborts the frame immediately; the line returns high with no glitch low.
- Push: on a rising edge with we=1 and a==DATA_ADDR, wd[7:0] is enqueued.
  - If the FIFO is full before that edge, the byte is dropped and sticky ovf is set.
  - This holds even if a pop happens on the same edge.
- Control: on a rising edge with we=1 and a==STAT_ADDR and wd[3]=1, ovf is cleared. Other wd bits are ignored.
- Read (combinational):
  - a==STAT_ADDR: rd = {28'b0, ovf, full, empty, busy}, i.e. bit0 busy, bit1 empty, bit2 full, bit3 ovf.
  - a==DATA_ADDR: rd = 0.
  - Otherwise: rd = 0 and sel = 0.
- FSM states IDLE → START → DATA → STOP → IDLE:
  - IDLE: if the FIFO is non-empty, pop into the shift register, load the baud counter with CLK_DIV-1, go to START. txd falls on the edge after the push edge (1-cycle latency).
  - START: txd=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each; a 3-bit index counts 0..7.
  - STOP: txd=1 for CLK_DIV cycles. Then go to IDLE, or directly to START with a pop if the FIFO is non-empty (back-to-back frames, no idle gap).
- Baud counter: decrements to 0, then reloads with CLK_DIV-1 and advances the bit. Frame length is exactly 10·CLK_DIV cycles.
- busy: 1 in START/DATA/STOP, 0 in IDLE.
- FIFO: read and write pointers of log2(FIFO_DEPTH)+1 bits, wrapping naturally. Empty when the pointers are equal; full when the MSBs differ and the rest match. Simultaneous push and pop when not full: both take effect and the count is unchanged.

Optional Feature:
MMIO_UART_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (^byte) for CLK_DIV cycles. Frame is 11·CLK_DIV cycles.
- Undefined: no PARITY state; 8N1 frame of 10·CLK_DIV cycles.

Decomposition:
- Package mmio_uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP), default DATA_ADDR/STAT_ADDR constants, status bit indices (ST_BUSY=0, ST_EMPTY=1, ST_FULL=2, ST_OVF=3).
- Sub-module byte_fifo (params DEPTH, WIDTH=8; ports clk, reset, push, pop, din, dout, empty, full): it is reusable for a later RX block.

Test Plan (CLK_DIV=4, FIFO_DEPTH=8):
1. Assert reset, release → txd=1, busy=0; with a=32'hFFFF_FF04, rd=32'h2 and sel=1.
2. Store 32'h0000_0055 to DATA_ADDR → txd=0 starting the next edge, then bits 1,0,1,0,1,0,1,0, then stop=1; each level held 4 cycles; busy high for exactly 40 cycles; STAT then reads 32'h2.
3. Store 0x00..0x09 to DATA_ADDR on 10 consecutive cycles → 0x00..0x08 transmitted in order with no gaps; 0x09 dropped; STAT bit3=1. Store 32'h8 to STAT_ADDR → bit3=0.
4. Store 0xA5, then drop reset to 0 during data bit 3 → txd=1 asynchronously, busy=0, FIFO empty; after release there is no further activity on txd.
5. Store 0x41 to 32'h0000_0040 → sel=0, rd=0, txd stays 1, FIFO stays empty.
6. With MMIO_UART_PARITY_EN, store 0x07 → data bits 1,1,1,0,0,0,0,0, parity=1, stop=1; frame is 44 cycles.
